// File: rtl/c7bbiu_ifill.sv
// I-cache line-fill responder: one dword or a 4-beat line per request, single outstanding memory read.
// Define C7B_BIU_CWF_EN for critical-word-first line fills; otherwise line fills start at beat 0.
module c7bbiu_ifill #(
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icu_biu_req,
  input  logic [28:0] icu_biu_addr,
  input  logic        icu_biu_single,
  output logic        biu_icu_ack,
  output logic        biu_icu_data_valid,
  output logic        biu_icu_data_last,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_fault,
  output logic        biu_mem_req,
  output logic [28:0] biu_mem_addr,
  input  logic        mem_biu_gnt,
  input  logic        mem_biu_rvalid,
  input  logic [63:0] mem_biu_rdata,
  input  logic        mem_biu_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state;
  logic [26:0] line_q;
  logic [1:0]  start_q;
  logic [1:0]  beat_cnt;
  logic        single_q;

  logic [1:0]  start_sel;
  logic [1:0]  next_idx;
  logic        beat_last;
  logic        accept;

`ifdef C7B_BIU_CWF_EN
  assign start_sel = icu_biu_addr[1:0];
`else
  assign start_sel = icu_biu_single ? icu_biu_addr[1:0] : 2'b00;
`endif

  assign next_idx  = start_q + beat_cnt + 2'd1;
  assign beat_last = single_q || (beat_cnt == 2'(LINE_BEATS - 1)) || mem_biu_err;
  // The first IDLE cycle after a last beat does not accept, so a new ack lands
  // two cycles after the final data_valid.
  assign accept    = icu_biu_req && !biu_icu_data_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      line_q             <= '0;
      start_q            <= '0;
      beat_cnt           <= '0;
      single_q           <= 1'b0;
      biu_icu_ack        <= 1'b0;
      biu_icu_data_valid <= 1'b0;
      biu_icu_data_last  <= 1'b0;
      biu_icu_data       <= '0;
      biu_icu_fault      <= 1'b0;
      biu_mem_req        <= 1'b0;
      biu_mem_addr       <= '0;
    end else begin
      biu_icu_ack        <= 1'b0;
      biu_icu_data_valid <= 1'b0;
      biu_icu_data_last  <= 1'b0;
      biu_icu_fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            line_q       <= icu_biu_addr[28:2];
            start_q      <= start_sel;
            single_q     <= icu_biu_single;
            beat_cnt     <= '0;
            biu_icu_ack  <= 1'b1;
            biu_mem_req  <= 1'b1;
            biu_mem_addr <= {icu_biu_addr[28:2], start_sel};
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_biu_gnt) begin
            biu_mem_req <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem_biu_rvalid) begin
            biu_icu_data_valid <= 1'b1;
            biu_icu_data       <= mem_biu_rdata;
            biu_icu_fault      <= mem_biu_err;
            biu_icu_data_last  <= beat_last;
            if (beat_last) begin
              state <= IDLE;
            end else begin
              beat_cnt     <= beat_cnt + 2'd1;
              biu_mem_req  <= 1'b1;
              biu_mem_addr <= {line_q, next_idx};
              state        <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/c7bbiu_ifill.md
# c7bbiu_ifill

Bus-interface responder for the instruction cache's line-fill port. Accepts fill requests from the ICU (`icu_biu_*`), fetches one doubleword or a full 4-beat, 32-byte line from a single-outstanding backing memory port, and returns the beats in order on `biu_icu_*`. Sits between the ICU and the memory/bus fabric, on the BIU side of the fill protocol.

## Interface
- `LINE_BEATS`, default 4: beats per line fill. Fixed at 4, matching the 32-byte line of four 64-bit doublewords.
- `clk` in 1: clock.
- `reset` in 1: reset, active-high and asynchronous.
- `icu_biu_req` in 1: fill request. The ICU holds it high until it sees `biu_icu_ack`.
- `icu_biu_addr` in 29: request address, [31:3].
- `icu_biu_single` in 1: 1 = single doubleword, 0 = full line.
- `biu_icu_ack` out 1: one-cycle request-accept pulse.
- `biu_icu_data_valid` out 1: return beat valid.
- `biu_icu_data_last` out 1: final beat of the transfer. Qualified by `data_valid`.
- `biu_icu_data` out 64: return data.
- `biu_icu_fault` out 1: beat carries a bus error. Qualified by `data_valid`.
- `biu_mem_req` out 1: memory read request. Held high until grant.
- `biu_mem_addr` out 29: memory doubleword address, [31:3].
- `mem_biu_gnt` in 1: request accepted this cycle.
- `mem_biu_rvalid` in 1: read data returned. At most one outstanding read.
- `mem_biu_rdata` in 64: read data.
- `mem_biu_err` in 1: error on the returned read. Qualified by `rvalid`.

## Operation
- FSM has three states: IDLE, ISSUE, WAIT.
- **IDLE**
  - When `icu_biu_req`=1, latch the address and `single`, and set the beat counter to 0.
  - Next cycle: pulse `biu_icu_ack` and enter ISSUE.
  - `mem_biu_rvalid` is ignored in IDLE.
- **ISSUE**
  - `biu_mem_req`=1 with `biu_mem_addr` = {line[31:5], beat_idx[1:0]}.
  - On `mem_biu_gnt`, go to WAIT. Address and req stay stable until the grant.
- **WAIT**
  - On `mem_biu_rvalid`, register the data and error onto `biu_icu_*` for one cycle.
  - `last` = single, or beat counter == 3, or err.
  - If `last`, go to IDLE; otherwise increment the counter and go to ISSUE.
- **Beat index**
  - 2-bit value, (start + counter) mod 4, so it wraps within the line.
  - `start` depends on the configuration; `single` always uses addr[4:3].
- **Fault**
  - An erroring beat is returned with `fault`=1, `last`=1 and the data forwarded unmodified.
  - Remaining beats are not issued.
- **`icu_biu_req` outside IDLE** is ignored. No queueing; the ICU keeps req high only until ack.
- **Reset, including mid-burst:** FSM to IDLE, counter to 0, all outputs 0. A stale `rvalid` arriving after reset is dropped.

## Timing
- Reset values:
  - `biu_icu_ack`, `data_valid`, `data_last`, `fault`, `biu_mem_req` = 0.
  - `biu_icu_data` = 0, `biu_mem_addr` = 0.
- `req` sampled in IDLE at cycle T:
  - `ack`=1 at T+1 only.
  - `biu_mem_req`=1 from T+1.
- Grant and data:
  - Grant at cycle G: WAIT from G+1.
  - `rvalid` at cycle R: `biu_icu_data_valid` at R+1.
  - When more beats remain, the next `biu_mem_req` is also at R+1.
- Best case is a full line with `gnt` in the same cycle as req and `rvalid` one cycle later.
  - Ack at T+1.
  - Beats at T+3, T+5, T+7, T+9; `last` at T+9.
- Back-to-back requests: after the `last` beat, the FSM is in IDLE.
  - The earliest new ack is 2 cycles after the `last` data_valid cycle.
- All `biu_icu_*` and `biu_mem_*` outputs are registered, with no combinational input-to-output paths.

## Configuration
- `C7B_BIU_CWF_EN` (critical-word-first):
  - **Defined:** a line fill starts at addr[4:3] and wraps. For example, addr[4:3]=2 returns beats 2,3,0,1.
  - **Undefined:** a line fill always starts at beat 0 (0,1,2,3) and ignores addr[4:3] for line fills.
  - `single` transfers are identical in both builds.

## Test plan
- **Single, no wait states:** req with addr=0x1000_0008>>3, single=1.
  - ack at T+1, mem_addr=0x0200_0001.
  - One beat with last=1, fault=0, data equal to the memory word.
  - FSM back in IDLE.
- **Line fill, addr[4:3]=2, CWF defined:** mem_addr sequence ...2, ...3, ...0, ...1.
  - Four data_valid beats, last only on the 4th.
  - Without the macro, the sequence is 0,1,2,3.
- **Grant stall:** gnt held low 5 cycles on beat 1.
  - mem_req and mem_addr stay stable throughout.
  - No data_valid until rvalid arrives.
  - Beat order is unchanged.
- **Fault on beat 1 of a line:** err=1 with rvalid.
  - Beat 1 returned with fault=1, last=1.
  - No further mem_req; FSM to IDLE.
  - The next req is acked normally.
- **Reset at beat 2 of a burst:** all outputs 0 next edge.
  - A late rvalid after reset produces no data_valid.
  - A fresh req after reset is acked at T+1.
- **req held high through a full burst:** exactly one ack; the second request is acked only after return to IDLE.
